// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst arbiter: drains NUM_PORTS ingress FIFOs, up to MAX_BURST
// words per grant, into one registered valid/ready channel tagged with the source port.
module fifo_rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_PORTS-1:0]            fifo_rd_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [PW-1:0]                   out_port,
  output logic                            busy
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         cur_q, cur_d;
  logic [BCW-1:0]        burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]         out_port_q, out_port_d;

  logic                  can_load_c;
  logic                  any_req_c;
  logic                  cur_empty_c;
  logic                  pop_c;
  logic                  last_c;
  logic                  dry_c;
  logic [PW-1:0]         sel_c;
  logic [PW-1:0]         cur_inc_c;
  logic [DATA_WIDTH-1:0] cur_word_c;
  logic [31:0]           scan_idx;

  // Head word and empty flag of the currently granted port
  always_comb begin
    cur_empty_c = 1'b1;
    cur_word_c  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (cur_q == PW'(i)) begin
        cur_empty_c = fifo_empty[PW'(i)];
        cur_word_c  = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // First non-empty port scanning upward from rr_ptr, modulo NUM_PORTS
  always_comb begin
    any_req_c = 1'b0;
    sel_c     = rr_ptr_q;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NUM_PORTS;
      if (!any_req_c && !fifo_empty[PW'(scan_idx)]) begin
        any_req_c = 1'b1;
        sel_c     = PW'(scan_idx);
      end
    end
  end

  assign cur_inc_c = (cur_q == PW'(NUM_PORTS - 1)) ? '0 : cur_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_req_c)       state_d = ST_GRANT;
      ST_GRANT: if (last_c || dry_c) state_d = ST_IDLE;
    endcase
  end

  // Pop strobe and burst-exit decode, valid only in GRANT
  always_comb begin
    busy       = 1'b0;
    pop_c      = 1'b0;
    dry_c      = 1'b0;
    fifo_rd_en = '0;
    can_load_c = !out_valid_q || out_ready;
    if (state_q == ST_GRANT) begin
      busy  = 1'b1;
      pop_c = can_load_c && !cur_empty_c;
      dry_c = can_load_c && cur_empty_c;
    end
    last_c = pop_c && (burst_cnt_q == BCW'(MAX_BURST - 1));
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      fifo_rd_en[PW'(i)] = pop_c && (cur_q == PW'(i));
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cur_d       = cur_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    if (state_q == ST_IDLE && any_req_c) begin
      cur_d       = sel_c;
      burst_cnt_d = '0;
    end
    if (pop_c) begin
      burst_cnt_d = burst_cnt_q + BCW'(1);
      out_valid_d = 1'b1;
      out_data_d  = cur_word_c;
      out_port_d  = cur_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // Granted port drops to lowest priority on every burst exit
    if (last_c || dry_c) begin
      rr_ptr_d = cur_inc_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cur_q       <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cur_q       <= cur_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: queue-based FIFOs, a cycle model of the
// arbitration rules, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

  localparam int NP  = 4;
  localparam int NP3 = 3;
  localparam int DW  = 8;
  localparam int MB  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NP-1:0]    fifo_empty;
  logic [NP*DW-1:0] fifo_rd_data;
  logic [NP-1:0]    fifo_rd_en;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_port;
  logic             busy;

  logic [NP3-1:0]    e3;
  logic [NP3*DW-1:0] d3;
  logic [NP3-1:0]    rd3;
  logic              ov3;
  logic              ready3 = 1'b1;
  logic [DW-1:0]     od3;
  logic [1:0]        op3;
  logic              busy3;

  int checks = 0;
  int errors = 0;

  logic [7:0] q  [NP][$];
  logic [7:0] q3 [NP3][$];
  logic [1:0] acc_p[$];
  logic [7:0] acc_d[$];
  logic [1:0] acc3_p[$];
  logic [7:0] acc3_d[$];
  logic [1:0] exp_p[$];
  logic [7:0] exp_d[$];

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_port(out_port), .busy(busy)
  );

  fifo_rr_arbiter #(.NUM_PORTS(NP3), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(e3), .fifo_rd_data(d3),
    .fifo_rd_en(rd3), .out_valid(ov3), .out_ready(ready3),
    .out_data(od3), .out_port(op3), .busy(busy3)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic refresh4();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]          = (q[i].size() == 0);
      fifo_rd_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic refresh3();
    for (int i = 0; i < NP3; i++) begin
      e3[i]          = (q3[i].size() == 0);
      d3[i*DW +: DW] = (q3[i].size() != 0) ? q3[i][0] : 8'h00;
    end
  endtask

  function automatic bit all_empty4();
    for (int i = 0; i < NP; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_empty3();
    for (int i = 0; i < NP3; i++) if (q3[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Model of the 4-port instance; pops the bench FIFOs as the rules dictate
  initial begin : cmp
    bit         m_gr, m_ov, can, found;
    int         m_cur, m_cnt, m_rr, m_op, p;
    logic [7:0] m_od;
    logic [NP-1:0] exp_en;
    m_gr = 0; m_ov = 0; m_cur = 0; m_cnt = 0; m_rr = 0; m_op = 0; m_od = 8'h00;
    refresh4();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_gr = 0; m_ov = 0; m_cur = 0; m_cnt = 0; m_rr = 0; m_op = 0; m_od = 8'h00;
      end
      can    = !m_ov || out_ready;
      exp_en = '0;
      if (rst_n && m_gr && can && q[m_cur].size() != 0) exp_en[m_cur] = 1'b1;
      chk("model rd_en",     32'(fifo_rd_en), 32'(exp_en));
      chk("model busy",      32'(busy),       32'(m_gr));
      chk("model out_valid", 32'(out_valid),  32'(m_ov));
      chk("model out_data",  32'(out_data),   32'(m_od));
      chk("model out_port",  32'(out_port),   32'(m_op));
      if (rst_n) begin
        if (out_valid && out_ready) begin
          acc_p.push_back(out_port);
          acc_d.push_back(out_data);
        end
        if (!m_gr) begin
          found = 0;
          for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (!found && q[p].size() != 0) begin
              found = 1; m_gr = 1; m_cur = p; m_cnt = 0;
            end
          end
        end else if (exp_en != '0) begin
          m_od = q[m_cur][0];
          m_op = m_cur;
          m_cnt++;
          if (m_cnt == MB) begin m_gr = 0; m_rr = (m_cur + 1) % NP; end
        end else if (can) begin
          m_gr = 0; m_rr = (m_cur + 1) % NP;
        end
        if (exp_en != '0) m_ov = 1;
        else if (m_ov && out_ready) m_ov = 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) if (exp_en[i] && q[i].size() != 0) void'(q[i].pop_front());
      refresh4();
    end
  end

  // FIFO emulation and invariant watch for the 3-port instance
  initial begin : d3proc
    logic [NP3-1:0] pend3;
    refresh3();
    forever begin
      @(negedge clk);
      pend3 = rd3;
      if (rst_n) begin
        chk("dut3 rd_en onehot/nonempty", 32'((rd3 & e3) | (rd3 & (rd3 - 3'd1))), 32'd0);
        if (ov3 && ready3) begin
          acc3_p.push_back(op3);
          acc3_d.push_back(od3);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NP3; i++) if (pend3[i] && q3[i].size() != 0) void'(q3[i].pop_front());
      refresh3();
    end
  end

  task automatic wait_idle4(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(all_empty4() && !out_valid && !busy) && n < 300);
    checks++;
    if (n >= 300) begin errors++; $display("FAIL %s idle timeout", nm); end
  endtask

  task automatic wait_idle3(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(all_empty3() && !ov3 && !busy3) && n < 300);
    checks++;
    if (n >= 300) begin errors++; $display("FAIL %s idle timeout", nm); end
  endtask

  task automatic add_exp(input logic [1:0] pp, input logic [7:0] dd);
    exp_p.push_back(pp);
    exp_d.push_back(dd);
  endtask

  task automatic clear_seq();
    acc_p.delete(); acc_d.delete(); acc3_p.delete(); acc3_d.delete();
    exp_p.delete(); exp_d.delete();
  endtask

  task automatic chk_seq(input string nm, input bit three);
    int na;
    na = three ? acc3_p.size() : acc_p.size();
    chk($sformatf("%s count", nm), 32'(na), 32'(exp_p.size()));
    for (int i = 0; i < exp_p.size(); i++) begin
      if (i < na) begin
        chk($sformatf("%s port[%0d]", nm, i), 32'(three ? acc3_p[i] : acc_p[i]), 32'(exp_p[i]));
        chk($sformatf("%s data[%0d]", nm, i), 32'(three ? acc3_d[i] : acc_d[i]), 32'(exp_d[i]));
      end
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] w1[3];
    w1[0] = 8'hA1; w1[1] = 8'hB2; w1[2] = 8'hC3;

    // Reset values
    @(negedge clk);
    chk("reset rd_en", 32'(fifo_rd_en), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 3-port wrap: port 1 alone (rr->2), port 1 again from rr=2, then 2 wraps to 0
    clear_seq();
    @(posedge clk); q3[1].push_back(8'h31);
    wait_idle3("w1");
    @(posedge clk); q3[1].push_back(8'h32);
    wait_idle3("w2");
    @(posedge clk); q3[0].push_back(8'h30); q3[2].push_back(8'h33);
    wait_idle3("w3");
    @(posedge clk); q3[1].push_back(8'h34); q3[2].push_back(8'h35);
    wait_idle3("w4");
    add_exp(2'd1, 8'h31); add_exp(2'd1, 8'h32); add_exp(2'd2, 8'h33);
    add_exp(2'd0, 8'h30); add_exp(2'd1, 8'h34); add_exp(2'd2, 8'h35);
    chk_seq("wrap3", 1'b1);

    // Single requester on port 2: one IDLE cycle then three pops
    clear_seq();
    @(posedge clk);
    for (int i = 0; i < 3; i++) q[2].push_back(w1[i]);
    @(negedge clk);
    chk("t1 idle rd_en", 32'(fifo_rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1 rd_en", 32'(fifo_rd_en), 32'b0100);
      if (i > 0) chk("t1 data", 32'(out_data), 32'(w1[i-1]));
    end
    @(negedge clk);
    chk("t1 last data", 32'(out_data), 32'(w1[2]));
    chk("t1 port", 32'(out_port), 32'd2);
    chk("t1 dry rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    chk("t1 back idle", 32'(busy), 32'd0);
    // rr_ptr must now be 3: port 3 beats port 0
    clear_seq();
    @(posedge clk); q[0].push_back(8'h0F); q[3].push_back(8'h3F);
    wait_idle4("t1b");
    add_exp(2'd3, 8'h3F); add_exp(2'd0, 8'h0F);
    chk_seq("rr3", 1'b0);

    // Round-robin between ports 0 and 1, rr_ptr=1 at start
    clear_seq();
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(8'(8'h00 + i));
      q[1].push_back(8'(8'h10 + i));
    end
    wait_idle4("t2");
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++)
        add_exp((b % 2 == 0) ? 2'd1 : 2'd0,
                8'(((b % 2 == 0) ? 16 : 0) + (b / 2) * 4 + j));
    chk_seq("rr01", 1'b0);

    // Backpressure mid-burst on port 2
    clear_seq();
    @(posedge clk);
    for (int i = 0; i < 6; i++) q[2].push_back(8'(8'h20 + i));
    repeat (3) @(posedge clk);
    #2 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp data", 32'(out_data), 32'h21);
      chk("bp port", 32'(out_port), 32'd2);
      chk("bp rd_en", 32'(fifo_rd_en), 32'd0);
      chk("bp valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_idle4("t3");
    for (int i = 0; i < 6; i++) add_exp(2'd2, 8'(8'h20 + i));
    chk_seq("bp", 1'b0);

    // Early empty on port 3: two pops, then dry exit without a pop
    clear_seq();
    @(posedge clk); q[3].push_back(8'h51); q[3].push_back(8'h52);
    @(negedge clk);
    chk("ee idle rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    chk("ee rd_en0", 32'(fifo_rd_en), 32'b1000);
    @(negedge clk);
    chk("ee rd_en1", 32'(fifo_rd_en), 32'b1000);
    @(negedge clk);
    chk("ee dry rd_en", 32'(fifo_rd_en), 32'd0);
    chk("ee dry busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ee exit busy", 32'(busy), 32'd0);
    wait_idle4("t5");
    add_exp(2'd3, 8'h51); add_exp(2'd3, 8'h52);
    chk_seq("ee", 1'b0);

    // Reset mid-burst: move rr_ptr to 3 first, then reset during a port-1 burst
    @(posedge clk); q[2].push_back(8'h61);
    wait_idle4("t6a");
    clear_seq();
    @(posedge clk);
    for (int i = 0; i < 4; i++) q[1].push_back(8'(8'h70 + i));
    repeat (2) @(posedge clk);
    q[3].push_back(8'h7F);
    #2;
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset valid", 32'(out_valid), 32'd0);
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle4("t6");
    add_exp(2'd1, 8'h71); add_exp(2'd1, 8'h72); add_exp(2'd1, 8'h73); add_exp(2'd3, 8'h7F);
    chk_seq("rst", 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
